// File: rtl/opc5ls_pkg.sv
// Shared definitions for the OPC5LS UART transmit port: register offsets,
// STATUS/CTRL bit positions and the transmitter state encoding.
package opc5ls_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_MSB = 12;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_FLUSH   = 2;
    localparam int CTRL_CLR_OVF = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/opc5ls_uart_tx_port_if.sv
// OPC5LS CPU bus as seen by one memory-mapped responder.
interface opc5ls_uart_tx_port_if;
    logic [15:0] address;
    logic        rnw;
    logic [15:0] din;
    logic [15:0] dout;
    logic        sel;

    modport master (output address, output rnw, output din, input dout, input sel);
    modport slave  (input address, input rnw, input din, output dout, output sel);
endinterface

// File: rtl/opc5ls_byte_fifo.sv
// Circular byte FIFO with separate count register; flush overrides push/pop.
module opc5ls_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [7:0]                 data_i,
    output logic [7:0]                 head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_s, pop_s;

    assign empty_o = (count_q == {CW{1'b0}});
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot first, so push while full is legal alongside a pop.
    assign pop_s  = pop_i & ~empty_o & ~flush_i;
    assign push_s = push_i & (~full_o | pop_s) & ~flush_i;

    // Next-state pointers and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end
endmodule

// File: rtl/opc5ls_uart_tx_port.sv
// OPC5LS memory-mapped 8N1 UART transmitter: zero-wait-state register file,
// byte FIFO and a START/DATA/STOP serialiser with programmable bit period.
module opc5ls_uart_tx_port
    import opc5ls_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFE00,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_DIV  = 16'd433
) (
    input  logic                  clk,
    input  logic                  reset,
    opc5ls_uart_tx_port_if.slave  bus,
    output logic                  txd,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   offset_s;
    logic          wr_s, wr_data_s, wr_div_s, wr_ctrl_s;
    logic          flush_s, clr_ovf_s, push_s, pop_s, start_ok_s;
    logic [7:0]    fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [15:0]   status_s, ctrl_s, rdata_s;

    logic [15:0]   div_q, div_d;
    logic          en_q, en_d, ie_q, ie_d, ovf_q, ovf_d, irq_q;
    tx_state_e     state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    // Unsigned subtraction wraps, so one compare covers both window edges.
    assign offset_s  = bus.address - BASE_ADDR;
    assign bus.sel   = (offset_s < 16'd4);
    assign wr_s      = bus.sel & ~bus.rnw;
    assign wr_data_s = wr_s & (offset_s[1:0] == REG_DATA);
    assign wr_div_s  = wr_s & (offset_s[1:0] == REG_DIV);
    assign wr_ctrl_s = wr_s & (offset_s[1:0] == REG_CTRL);
    assign flush_s   = wr_ctrl_s & bus.din[CTRL_FLUSH];
    assign clr_ovf_s = wr_ctrl_s & bus.din[CTRL_CLR_OVF];
    assign push_s    = wr_data_s & (~fifo_full_s | pop_s);
    assign start_ok_s = en_q & ~fifo_empty_s;

    opc5ls_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .data_i  (bus.din[7:0]),
        .head_o  (fifo_head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Register-file next state.
    always_comb begin
        div_d = div_q;
        en_d  = en_q;
        ie_d  = ie_q;
        ovf_d = ovf_q;
        if (wr_div_s) begin
            div_d = bus.din;
        end else begin
            div_d = div_q;
        end
        if (wr_ctrl_s) begin
            en_d = bus.din[CTRL_EN];
            ie_d = bus.din[CTRL_IE];
        end else begin
            en_d = en_q;
            ie_d = ie_q;
        end
        if (wr_data_s & fifo_full_s & ~pop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmitter next state; STOP chains straight into START when data waits.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop_s   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start_ok_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_head_s;
                    baud_d  = div_q;
                    txd_d   = 1'b0;
                    state_d = TX_START;
                end else begin
                    txd_d   = 1'b1;
                end
            end
            TX_START: begin
                if (baud_q == 16'd0) begin
                    state_d = TX_DATA;
                    baud_d  = div_q;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = div_q;
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (baud_q == 16'd0) begin
                    if (start_ok_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_head_s;
                        baud_d  = div_q;
                        txd_d   = 1'b0;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= RESET_DIV;
            en_q    <= 1'b1;
            ie_q    <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            state_q <= TX_IDLE;
            baud_q  <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            div_q   <= div_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            ovf_q   <= ovf_d;
            irq_q   <= ie_q & fifo_empty_s & (state_q == TX_IDLE);
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Side-effect-free read mux; zero when unselected for OR-merging.
    always_comb begin
        status_s = 16'h0000;
        status_s[ST_BUSY]  = (state_q != TX_IDLE);
        status_s[ST_FULL]  = fifo_full_s;
        status_s[ST_EMPTY] = fifo_empty_s;
        status_s[ST_OVF]   = ovf_q;
        status_s[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count_s);
        ctrl_s = 16'h0000;
        ctrl_s[CTRL_EN] = en_q;
        ctrl_s[CTRL_IE] = ie_q;
        rdata_s = 16'h0000;
        if (bus.sel) begin
            case (offset_s[1:0])
                REG_DATA:   rdata_s = 16'h0000;
                REG_STATUS: rdata_s = status_s;
                REG_DIV:    rdata_s = div_q;
                REG_CTRL:   rdata_s = ctrl_s;
                default:    rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign bus.dout = rdata_s;
    assign txd      = txd_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_opc5ls_uart_tx_port.sv
// Directed self-checking bench for opc5ls_uart_tx_port.
module tb_opc5ls_uart_tx_port;
    logic clk;
    logic reset;
    logic txd;
    logic irq;
    int   n_checks;
    int   n_fail;

    opc5ls_uart_tx_port_if bus_if ();

    opc5ls_uart_tx_port #(
        .BASE_ADDR  (16'hFE00),
        .FIFO_DEPTH (4),
        .RESET_DIV  (16'd433)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .txd   (txd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 16'h%04h, required 16'h%04h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus_if.address = addr;
        bus_if.din     = data;
        bus_if.rnw     = 1'b0;
        @(posedge clk);
        #1;
        bus_if.rnw     = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        bus_if.address = addr;
        bus_if.rnw     = 1'b1;
        #1;
        data = bus_if.dout;
    endtask

    logic [15:0] rd;
    logic [9:0]  frame;
    logic [19:0] stream;
    int          lows;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus_if.address = 16'h0000;
        bus_if.rnw     = 1'b1;
        bus_if.din     = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and readback
        bus_read(16'hFE01, rd); check_eq("rst_status", rd, 16'h0004);
        bus_read(16'hFE02, rd); check_eq("rst_div", rd, 16'd433);
        bus_read(16'hFE03, rd); check_eq("rst_ctrl", rd, 16'h0001);
        check_eq("rst_txd", {15'd0, txd}, 16'h0001);
        check_eq("rst_irq", {15'd0, irq}, 16'h0000);
        bus_read(16'hFE04, rd); check_eq("oob_dout", rd, 16'h0000);
        check_eq("oob_sel", {15'd0, bus_if.sel}, 16'h0000);
        bus_read(16'hFE00, rd); check_eq("data_reads_0", rd, 16'h0000);

        // Single frame, DIV=3 -> 4 clocks per bit
        bus_write(16'hFE02, 16'd3);
        bus_write(16'hFE00, 16'h1255);
        bus_if.address = 16'hFE01;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("frame1_bit%0d_clk%0d", i / 4, i % 4), {15'd0, txd}, {15'd0, frame[i / 4]});
            if (i == 20) check_eq("frame1_busy", {15'd0, bus_if.dout[0]}, 16'h0001);
        end
        repeat (2) @(posedge clk);
        bus_read(16'hFE01, rd); check_eq("frame1_done_status", rd, 16'h0004);

        // Overflow and flush with transmitter disabled
        bus_write(16'hFE03, 16'h0000);
        for (int i = 0; i < 5; i++) bus_write(16'hFE00, 16'(8'h10 + i));
        bus_read(16'hFE01, rd); check_eq("ovf_status", rd, 16'h040A);
        bus_write(16'hFE03, 16'h000C);
        bus_read(16'hFE01, rd); check_eq("flush_status", rd, 16'h0004);
        bus_read(16'hFE03, rd); check_eq("flush_ctrl", rd, 16'h0000);

        // Back-to-back frames with DIV=0, irq after second stop bit
        bus_write(16'hFE02, 16'h0000);
        bus_write(16'hFE00, 16'h00A5);
        bus_write(16'hFE00, 16'h003C);
        bus_write(16'hFE03, 16'h0003);
        stream = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            if (i < 20) check_eq($sformatf("b2b_bit%0d", i), {15'd0, txd}, {15'd0, stream[i]});
            check_eq($sformatf("b2b_irq%0d", i), {15'd0, irq}, (i == 21) ? 16'h0001 : 16'h0000);
        end

        // Push while full in the IDLE->START pop cycle
        bus_write(16'hFE03, 16'h0000);
        for (int i = 0; i < 4; i++) bus_write(16'hFE00, 16'(8'h20 + i));
        bus_read(16'hFE01, rd); check_eq("pp_full_status", rd, 16'h0402);
        bus_write(16'hFE03, 16'h0001);
        bus_write(16'hFE00, 16'h0024);
        bus_read(16'hFE01, rd); check_eq("pp_status", rd, 16'h0403);
        repeat (60) @(posedge clk);
        bus_read(16'hFE01, rd); check_eq("pp_drained_status", rd, 16'h0004);

        // Reset in the middle of the DATA state
        bus_write(16'hFE02, 16'd3);
        bus_write(16'hFE00, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_data_txd", {15'd0, txd}, 16'h0000);
        #2 reset = 1'b1;
        #1 check_eq("async_rst_txd", {15'd0, txd}, 16'h0001);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read(16'hFE01, rd); check_eq("post_rst_status", rd, 16'h0004);
        bus_read(16'hFE02, rd); check_eq("post_rst_div", rd, 16'd433);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check_eq("post_rst_no_frame", 16'(lows), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/opc5ls_uart_tx_port.md
Name: opc5ls_uart_tx_port

Overview:
Memory-mapped bus responder for the OPC5LS CPU bus. It sits on the CPU's address, data-out, data-in and rnw lines.
- Accepts 16-bit word writes into a small byte FIFO.
- Serialises FIFO bytes as 8N1 frames on a txd pin.
- Returns status and config words on reads with zero wait states, because the CPU has no wait input.

Parameters:
- BASE_ADDR, 16'hFE00: word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2, range 2..16.
- RESET_DIV, 16'd433: reset value of the baud divisor; bit period = DIV+1 clocks.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  16  CPU word address.
- rnw  in  1  1 = read/idle, 0 = write this cycle.
- din  in  16  CPU write data.
- dout  out  16  read data to CPU; 16'h0000 when not selected, so it can be OR-merged with other responders.
- sel  out  1  combinational: address is within the decoded window.
- txd  out  1  serial output, idle high.
- irq  out  1  registered: FIFO empty AND transmitter idle AND CTRL.ie.

Behaviour:
- Bus timing:
  - A write occurs when sel & !rnw at the rising edge; din is captured on that edge.
  - Reads are purely combinational from current register state; the CPU samples at the same edge.
  - Reads have no side effects. The CPU drives PC on address during fetch, so reads must never pop or clear anything.
- Register map (offset = address - BASE_ADDR):
  - 0 DATA. Write pushes din[7:0]; din[15:8] is ignored. Read returns 0.
  - 1 STATUS (read only; writes ignored):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 ovf (sticky)
    - bits8..12 count (0..FIFO_DEPTH)
    - other bits 0
  - 2 DIV. Read/write, full 16 bits.
  - 3 CTRL. bit0 en (R/W), bit1 ie (R/W), bit2 flush (write-1, reads 0), bit3 clr_ovf (write-1, reads 0).
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH; count is held as a separate register.
  - Write to DATA when full: byte dropped, ovf set, FIFO unchanged.
  - Push and pop in the same cycle: count unchanged; both pointers advance (legal even when full, because the pop frees a slot first).
  - Flush: both pointers and count go to 0 on the next edge. A frame already in progress completes. A push in the same cycle as flush is discarded.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - Baud counter loads DIV at each bit start and counts down to 0. Each bit lasts DIV+1 clocks.
  - IDLE: txd=1. If en and !empty, pop the FIFO head into the shift register and go to START.
  - START: txd=0 for one bit.
  - DATA: 8 bits, LSB first; a 3-bit index counts 0..7.
  - STOP: txd=1 for one bit, then IDLE. A next byte, if available, starts the cycle after STOP ends, so back-to-back frames have no extra idle bit.
  - en cleared mid-frame: the current frame finishes and no new frame starts.
  - DIV written mid-frame: takes effect at the next bit boundary.
  - DIV=0: bit period is 1 clock; this is legal.
- Reset values (asynchronous, immediate): FSM IDLE, txd=1, FIFO empty, pointers 0, ovf=0, en=1, ie=0, DIV=RESET_DIV, irq=0. A frame in progress is aborted.

Decomposition:
- Shared package opc5ls_pkg:
  - register offset constants REG_DATA=0, REG_STATUS=1, REG_DIV=2, REG_CTRL=3
  - STATUS and CTRL bit-position constants
  - TX FSM state encoding
- One sub-module, opc5ls_byte_fifo: parameterised depth, push/pop/flush inputs, count/full/empty outputs, head data output. The top level holds bus decode, the register file, and the TX FSM.

Test Plan:
- Reset and readback: assert reset; then read offset 1 -> 16'h0004; read offset 2 -> 16'd433; read offset 3 -> 16'h0001; txd=1. A read at address BASE_ADDR+4 -> dout=0, sel=0.
- Single frame: write DIV=3, then DATA=16'h1255. Required txd: start bit, then bits 1,0,1,0,1,0,1,0, then stop bit, each exactly 4 clocks (40 clocks total). While transmitting, STATUS busy=1. Afterwards STATUS=16'h0004.
- Overflow and flush: set en=0, write 5 bytes -> STATUS count=4, full=1, ovf=1. Write CTRL=16'h000C (flush + clr_ovf, en=0) -> STATUS=16'h0004.
- Back-to-back: set DIV=0, queue 16'hA5 and 16'h3C, en=1. Required: two frames with no idle clock between the first stop bit and the second start bit. irq rises only after the second stop bit when ie=1.
- Simultaneous push/pop: with FIFO full and the FSM in the IDLE->START pop cycle, write a DATA byte -> accepted, count stays 4, ovf stays 0.
- Reset mid-frame: assert reset during the DATA state -> txd=1 asynchronously. After deassert, STATUS=16'h0004 and no residual frame is sent.
